// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: opcodes, ALU ops, immediate formats, control bundle.
// Used by the decode stage and by the execute stage.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  typedef struct packed {
    alu_op_e    alu_op;
    logic [2:0] funct3;
    logic       alu_src_imm;
    logic       op1_pc;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       jump;
  } ctrl_t;

  function automatic logic [31:0] gen_imm(
    input logic [31:0] i,
    input imm_type_e   t
  );
    logic [31:0] r;
    unique case (t)
      IMM_I:   r = {{20{i[31]}}, i[31:20]};
      IMM_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   r = {{19{i[31]}}, i[31], i[7],
                    i[30:25], i[11:8], 1'b0};
      IMM_U:   r = {i[31:12], 12'b0};
      IMM_J:   r = {{11{i[31]}}, i[31], i[19:12],
                    i[20], i[30:21], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Decode stage bus: IF/ID handshake, register file ports, writeback, ID/EX slot.
// master = upstream/environment side, slave = decode_stage.
interface decode_stage_if;
  import riscv_pkg::*;

  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;
  logic            id_ready;
  logic            flush;

  logic [5:0]      rf_read1_id;
  logic [5:0]      rf_read2_id;
  logic [31:0]     rf_read1_data;
  logic [31:0]     rf_read2_data;

  logic            wb_write_en;
  logic [4:0]      wb_write_id;
  logic [31:0]     wb_write_data;

  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [31:0]     ex_rs1_data;
  logic [31:0]     ex_rs2_data;
  logic [31:0]     ex_imm;
  logic [14:0]     ex_regs;
  ctrl_t           ex_ctrl;
  logic            ex_illegal;

  modport master (
    output if_valid, if_pc, if_instr, flush,
    output rf_read1_data, rf_read2_data,
    output wb_write_en, wb_write_id, wb_write_data,
    input  id_ready, rf_read1_id, rf_read2_id,
    input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data,
    input  ex_imm, ex_regs, ex_ctrl, ex_illegal
  );

  modport slave (
    input  if_valid, if_pc, if_instr, flush,
    input  rf_read1_data, rf_read2_data,
    input  wb_write_en, wb_write_id, wb_write_data,
    output id_ready, rf_read1_id, rf_read2_id,
    output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data,
    output ex_imm, ex_regs, ex_ctrl, ex_illegal
  );
endinterface

// File: rtl/instr_decoder.sv
// RV32I combinational decoder: instruction word to control bundle,
// immediate, illegal flag and source-register usage.
module instr_decoder
  import riscv_pkg::*;
(
  input  logic [31:0] i_instr,
  output ctrl_t       o_ctrl,
  output logic [31:0] o_imm,
  output logic        o_illegal,
  output logic        o_rs1_used,
  output logic        o_rs2_used
);

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic       w_alt;
  logic       w_lui, w_auipc, w_jal, w_jalr;
  logic       w_br, w_ld, w_st, w_opi, w_op, w_fence;
  alu_op_e    w_arith;
  imm_type_e  w_imm_type;

  assign w_opc   = i_instr[6:0];
  assign w_f3    = i_instr[14:12];
  assign w_alt   = i_instr[30];
  assign w_lui   = (w_opc == OPC_LUI);
  assign w_auipc = (w_opc == OPC_AUIPC);
  assign w_jal   = (w_opc == OPC_JAL);
  assign w_jalr  = (w_opc == OPC_JALR);
  assign w_br    = (w_opc == OPC_BRANCH);
  assign w_ld    = (w_opc == OPC_LOAD);
  assign w_st    = (w_opc == OPC_STORE);
  assign w_opi   = (w_opc == OPC_OPIMM);
  assign w_op    = (w_opc == OPC_OP);
  assign w_fence = (w_opc == OPC_MISCMEM);

  // SUB only exists in register form; ADDI ignores bit 30
  always_comb begin
    w_arith = ALU_ADD;
    unique case (w_f3)
      3'b000: w_arith = (w_op && w_alt) ? ALU_SUB : ALU_ADD;
      3'b001: w_arith = ALU_SLL;
      3'b010: w_arith = ALU_SLT;
      3'b011: w_arith = ALU_SLTU;
      3'b100: w_arith = ALU_XOR;
      3'b101: w_arith = w_alt ? ALU_SRA : ALU_SRL;
      3'b110: w_arith = ALU_OR;
      3'b111: w_arith = ALU_AND;
    endcase
  end

  always_comb begin
    o_ctrl     = '0;
    o_illegal  = 1'b0;
    o_rs1_used = 1'b0;
    o_rs2_used = 1'b0;
    w_imm_type = IMM_NONE;
    unique case (1'b1)
      w_lui: begin
        w_imm_type         = IMM_U;
        o_ctrl.alu_op      = ALU_PASSB;
        o_ctrl.alu_src_imm = 1'b1;
        o_ctrl.reg_write   = 1'b1;
      end
      w_auipc: begin
        w_imm_type         = IMM_U;
        o_ctrl.alu_src_imm = 1'b1;
        o_ctrl.op1_pc      = 1'b1;
        o_ctrl.reg_write   = 1'b1;
      end
      w_jal: begin
        w_imm_type         = IMM_J;
        o_ctrl.alu_src_imm = 1'b1;
        o_ctrl.op1_pc      = 1'b1;
        o_ctrl.reg_write   = 1'b1;
        o_ctrl.jump        = 1'b1;
      end
      w_jalr: begin
        w_imm_type         = IMM_I;
        o_ctrl.alu_src_imm = 1'b1;
        o_ctrl.reg_write   = 1'b1;
        o_ctrl.jump        = 1'b1;
        o_rs1_used         = 1'b1;
      end
      w_br: begin
        w_imm_type    = IMM_B;
        o_ctrl.alu_op = ALU_SUB;
        o_ctrl.branch = 1'b1;
        o_rs1_used    = 1'b1;
        o_rs2_used    = 1'b1;
      end
      w_ld: begin
        w_imm_type         = IMM_I;
        o_ctrl.alu_src_imm = 1'b1;
        o_ctrl.mem_read    = 1'b1;
        o_ctrl.reg_write   = 1'b1;
        o_rs1_used         = 1'b1;
      end
      w_st: begin
        w_imm_type         = IMM_S;
        o_ctrl.alu_src_imm = 1'b1;
        o_ctrl.mem_write   = 1'b1;
        o_rs1_used         = 1'b1;
        o_rs2_used         = 1'b1;
      end
      w_opi: begin
        w_imm_type         = IMM_I;
        o_ctrl.alu_op      = w_arith;
        o_ctrl.alu_src_imm = 1'b1;
        o_ctrl.reg_write   = 1'b1;
        o_rs1_used         = 1'b1;
      end
      w_op: begin
        o_ctrl.alu_op    = w_arith;
        o_ctrl.reg_write = 1'b1;
        o_rs1_used       = 1'b1;
        o_rs2_used       = 1'b1;
      end
      w_fence: o_ctrl = '0;
      default: o_illegal = 1'b1;
    endcase
    o_ctrl.funct3 = (o_illegal || w_fence) ? 3'b000 : w_f3;
  end

  assign o_imm = gen_imm(i_instr, w_imm_type);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with ID/EX register, load-use stall and branch flush.
// DECODE_WB_BYPASS_EN: forward writeback data; otherwise a WB match stalls.
module decode_stage
  import riscv_pkg::*;
(
  input logic          clk,
  input logic          reset_n,
  decode_stage_if.slave bus
);

  ctrl_t           w_ctrl;
  logic [31:0]     w_imm;
  logic            w_illegal, w_rs1_used, w_rs2_used;
  logic [4:0]      w_rs1, w_rs2, w_rd, w_ex_rd;
  logic            w_lu_hit, w_wb_hit1, w_wb_hit2;
  logic            w_hz, w_issue;
  logic [31:0]     w_op1, w_op2;

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_rs1_data, r_rs2_data, r_imm;
  logic [14:0]     r_regs;
  ctrl_t           r_ctrl;
  logic            r_illegal;

  instr_decoder u_dec (
    .i_instr    (bus.if_instr),
    .o_ctrl     (w_ctrl),
    .o_imm      (w_imm),
    .o_illegal  (w_illegal),
    .o_rs1_used (w_rs1_used),
    .o_rs2_used (w_rs2_used)
  );

  assign w_rs1   = bus.if_instr[19:15];
  assign w_rs2   = bus.if_instr[24:20];
  assign w_rd    = bus.if_instr[11:7];
  assign w_ex_rd = r_regs[4:0];

  assign bus.rf_read1_id = {1'b0, w_rs1};
  assign bus.rf_read2_id = {1'b0, w_rs2};

  // if_valid stays out of the stall term so id_ready never loops back upstream
  assign w_lu_hit = r_valid && r_ctrl.mem_read && (w_ex_rd != 5'd0) &&
                    ((w_rs1_used && (w_rs1 == w_ex_rd)) ||
                     (w_rs2_used && (w_rs2 == w_ex_rd)));

  assign w_wb_hit1 = bus.wb_write_en && (bus.wb_write_id != 5'd0) &&
                     (bus.wb_write_id == w_rs1);
  assign w_wb_hit2 = bus.wb_write_en && (bus.wb_write_id != 5'd0) &&
                     (bus.wb_write_id == w_rs2);

`ifdef DECODE_WB_BYPASS_EN
  assign w_hz  = w_lu_hit;
  assign w_op1 = w_wb_hit1 ? bus.wb_write_data : bus.rf_read1_data;
  assign w_op2 = w_wb_hit2 ? bus.wb_write_data : bus.rf_read2_data;
`else
  assign w_hz  = w_lu_hit ||
                 (w_rs1_used && w_wb_hit1) ||
                 (w_rs2_used && w_wb_hit2);
  assign w_op1 = bus.rf_read1_data;
  assign w_op2 = bus.rf_read2_data;
`endif

  assign bus.id_ready = bus.flush || !w_hz;
  assign w_issue      = bus.if_valid && !bus.flush && !w_hz;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_regs     <= '0;
      r_ctrl     <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_valid    <= w_issue;
      r_pc       <= bus.if_pc;
      r_rs1_data <= w_op1;
      r_rs2_data <= w_op2;
      r_imm      <= w_imm;
      r_regs     <= {w_rs1, w_rs2, w_rd};
      r_ctrl     <= w_issue ? w_ctrl : '0;
      r_illegal  <= w_issue && w_illegal;
    end
  end

  assign bus.ex_valid    = r_valid;
  assign bus.ex_pc       = r_pc;
  assign bus.ex_rs1_data = r_rs1_data;
  assign bus.ex_rs2_data = r_rs2_data;
  assign bus.ex_imm      = r_imm;
  assign bus.ex_regs     = r_regs;
  assign bus.ex_ctrl     = r_ctrl;
  assign bus.ex_illegal  = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed cases then random instruction
// streams checked against a behavioural decode and hazard model.
module tb_decode_stage;
  import riscv_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [14:0] regs;
    ctrl_t       ctrl;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] rf [32];
  logic [31:0] pc;
  exp_t        sb [$];
  exp_t        e;
  int          n_chk = 0;
  int          n_fail = 0;

  bit          m_live, m_load;
  logic [4:0]  m_rd;

  alu_op_e f3_alu [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                          ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};

  decode_stage_if bus ();

  decode_stage dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  assign bus.rf_read1_data = rf[bus.rf_read1_id[4:0]];
  assign bus.rf_read2_data = rf[bus.rf_read2_id[4:0]];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic void ref_dec(
    input  logic [31:0] w,
    output ctrl_t       c,
    output logic [31:0] imm,
    output bit          ill,
    output bit          u1,
    output bit          u2
  );
    logic [31:0] vi, vs, vb, vu, vj;
    alu_op_e     a;
    vi = 32'($signed(w[31:20]));
    vs = 32'($signed({w[31:25], w[11:7]}));
    vb = (w[31] ? -32'd4096 : 32'd0) + 32'(w[7]) * 2048 +
         32'(w[30:25]) * 32 + 32'(w[11:8]) * 2;
    vu = 32'(w[31:12]) * 4096;
    vj = (w[31] ? -32'd1048576 : 32'd0) + 32'(w[19:12]) * 4096 +
         32'(w[20]) * 2048 + 32'(w[30:21]) * 2;
    a = f3_alu[w[14:12]];
    if (w[14:12] == 3'd5 && w[30]) a = ALU_SRA;
    c = '0; imm = '0; ill = 0; u1 = 0; u2 = 0;
    case (w[6:0])
      OPC_LUI: begin
        imm = vu; c.alu_op = ALU_PASSB;
        c.alu_src_imm = 1; c.reg_write = 1;
      end
      OPC_AUIPC: begin
        imm = vu; c.alu_src_imm = 1; c.op1_pc = 1; c.reg_write = 1;
      end
      OPC_JAL: begin
        imm = vj; c.alu_src_imm = 1; c.op1_pc = 1;
        c.reg_write = 1; c.jump = 1;
      end
      OPC_JALR: begin
        imm = vi; c.alu_src_imm = 1; c.reg_write = 1;
        c.jump = 1; u1 = 1;
      end
      OPC_BRANCH: begin
        imm = vb; c.alu_op = ALU_SUB; c.branch = 1; u1 = 1; u2 = 1;
      end
      OPC_LOAD: begin
        imm = vi; c.alu_src_imm = 1; c.mem_read = 1;
        c.reg_write = 1; u1 = 1;
      end
      OPC_STORE: begin
        imm = vs; c.alu_src_imm = 1; c.mem_write = 1; u1 = 1; u2 = 1;
      end
      OPC_OPIMM: begin
        imm = vi; c.alu_op = a; c.alu_src_imm = 1;
        c.reg_write = 1; u1 = 1;
      end
      OPC_OP: begin
        if (w[14:12] == 3'd0 && w[30]) a = ALU_SUB;
        c.alu_op = a; c.reg_write = 1; u1 = 1; u2 = 1;
      end
      OPC_MISCMEM: ;
      default: ill = 1;
    endcase
    if (!ill && w[6:0] != OPC_MISCMEM) c.funct3 = w[14:12];
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] rs,
                                       input bit we,
                                       input logic [4:0] wid,
                                       input logic [31:0] wd);
`ifdef DECODE_WB_BYPASS_EN
    if (we && wid != 0 && wid == rs) return wd;
`endif
    return rf[rs];
  endfunction

  task automatic step(input bit v, input logic [31:0] ins,
                      input bit fl, input bit we,
                      input logic [4:0] wid, input logic [31:0] wd,
                      output bit st);
    ctrl_t c;
    logic [31:0] imm;
    bit ill, u1, u2, hz, rdy, iss;
    logic [4:0] r1, r2;
    exp_t x;
    bus.if_valid = v; bus.if_instr = ins; bus.if_pc = pc;
    bus.flush = fl; bus.wb_write_en = we;
    bus.wb_write_id = wid; bus.wb_write_data = wd;
    #1;
    ref_dec(ins, c, imm, ill, u1, u2);
    r1 = ins[19:15]; r2 = ins[24:20];
    hz = m_live && m_load && m_rd != 0 &&
         ((u1 && r1 == m_rd) || (u2 && r2 == m_rd));
`ifndef DECODE_WB_BYPASS_EN
    hz = hz || (we && wid != 0 &&
                ((u1 && wid == r1) || (u2 && wid == r2)));
`endif
    rdy = fl || !hz;
    if (v) chk("id_ready", 64'(bus.id_ready), 64'(rdy));
    chk("rf_read1_id", 64'(bus.rf_read1_id), 64'({1'b0, r1}));
    chk("rf_read2_id", 64'(bus.rf_read2_id), 64'({1'b0, r2}));
    iss = v && !fl && !hz;
    if (iss) begin
      x.pc = pc; x.imm = imm; x.ctrl = c; x.ill = ill;
      x.rs1 = opnd(r1, we, wid, wd);
      x.rs2 = opnd(r2, we, wid, wd);
      x.regs = {r1, r2, ins[11:7]};
      sb.push_back(x);
    end
    m_live = iss;
    m_load = iss && ins[6:0] == OPC_LOAD;
    m_rd = ins[11:7];
    st = v && !rdy;
    @(posedge clk);
    #1;
    if (we && wid != 0) rf[wid] = wd;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.ex_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_issue_pc", 64'(bus.ex_pc), 64'hFFFF_FFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("ex_pc", 64'(bus.ex_pc), 64'(e.pc));
          chk("ex_rs1_data", 64'(bus.ex_rs1_data), 64'(e.rs1));
          chk("ex_rs2_data", 64'(bus.ex_rs2_data), 64'(e.rs2));
          chk("ex_imm", 64'(bus.ex_imm), 64'(e.imm));
          chk("ex_regs", 64'(bus.ex_regs), 64'(e.regs));
          chk("ex_ctrl", 64'(bus.ex_ctrl), 64'(e.ctrl));
          chk("ex_illegal", 64'(bus.ex_illegal), 64'(e.ill));
        end
      end else begin
        chk("bubble_ctrl", 64'({bus.ex_ctrl, bus.ex_illegal}), 64'd0);
      end
    end
  end

  function automatic logic [31:0] rnd_instr();
    logic [6:0] ops [13] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
                             OPC_BRANCH, OPC_LOAD, OPC_LOAD, OPC_STORE,
                             OPC_OPIMM, OPC_OP, OPC_MISCMEM, OPC_SYSTEM,
                             7'b0110000};
    logic [31:0] w;
    w = $urandom;
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    w[11:7]  = 5'($urandom_range(0, 7));
    w[6:0]   = ops[$urandom_range(0, 12)];
    return w;
  endfunction

  initial begin
    bit st, v, fl, we;
    logic [31:0] ins, wd;
    logic [4:0] wid;
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
    bus.if_valid = 0; bus.if_pc = 0; bus.if_instr = 0; bus.flush = 0;
    bus.wb_write_en = 0; bus.wb_write_id = 0; bus.wb_write_data = 0;
    m_live = 0; m_load = 0; m_rd = 0; pc = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", 64'({bus.ex_valid, bus.ex_illegal, bus.ex_ctrl,
                           bus.ex_regs}), 64'd0);
    chk("reset_data", 64'(bus.ex_pc | bus.ex_imm | bus.ex_rs1_data |
                          bus.ex_rs2_data), 64'd0);
    reset_n = 1;

    step(1, 32'h0070_0293, 0, 0, 0, 0, st);
    chk("addi_valid", 64'(bus.ex_valid), 64'd1);
    chk("addi_imm", 64'(bus.ex_imm), 64'd7);
    chk("addi_rd", 64'(bus.ex_regs[4:0]), 64'd5);
    chk("addi_ctrl", 64'({bus.ex_ctrl.alu_src_imm, bus.ex_ctrl.reg_write}),
        64'd3);

    pc = 32'h104; step(1, 32'h0002_A303, 0, 0, 0, 0, st);
    pc = 32'h108; step(1, 32'h0063_03B3, 0, 0, 0, 0, st);
    chk("lu_stall", 64'(st), 64'd1);
    chk("lu_bubble", 64'(bus.ex_valid), 64'd0);
    step(1, 32'h0063_03B3, 0, 0, 0, 0, st);
    chk("lu_issue", 64'({bus.ex_valid, bus.ex_regs[14:5]}),
        64'({1'b1, 5'd6, 5'd6}));

    pc = 32'h10C; step(1, 32'hFE20_8CE3, 1, 0, 0, 0, st);
    chk("flush_drop", 64'({st, bus.ex_valid}), 64'd0);
    pc = 32'h110; step(1, 32'h0002_A303, 0, 0, 0, 0, st);
    pc = 32'h114; step(1, 32'h0063_03B3, 1, 0, 0, 0, st);
    chk("flush_over_hz", 64'({st, bus.ex_valid}), 64'd0);

    rf[10] = 32'h1;
    pc = 32'h118; step(1, 32'h0005_05B3, 0, 1, 10, 32'hDEADBEEF, st);
`ifdef DECODE_WB_BYPASS_EN
    chk("bypass_nostall", 64'(st), 64'd0);
`else
    chk("wb_stall", 64'(st), 64'd1);
    step(1, 32'h0005_05B3, 0, 0, 0, 0, st);
`endif
    chk("bypass_rs1", 64'(bus.ex_rs1_data), 64'hDEADBEEF);
    pc = 32'h11C; step(1, 32'h0000_05B3, 0, 1, 0, 32'h1234, st);
    chk("wb_x0", 64'({st, bus.ex_rs1_data}), 64'd0);

    pc = 32'h120; step(1, 32'hFFFF_FFFF, 0, 0, 0, 0, st);
    chk("illegal", 64'({bus.ex_valid, bus.ex_illegal, bus.ex_ctrl}),
        64'({2'b11, 14'd0}));

    pc = 32'h124; step(1, 32'h0002_A303, 0, 0, 0, 0, st);
    bus.if_instr = 32'h0063_03B3; bus.if_pc = 32'h128;
    #1;
    chk("stall_before_reset", 64'(bus.id_ready), 64'd0);
    reset_n = 0;
    #1;
    chk("async_reset_ctrl", 64'({bus.ex_valid, bus.ex_illegal,
                                 bus.ex_ctrl, bus.ex_regs}), 64'd0);
    chk("async_reset_data", 64'(bus.ex_pc | bus.ex_imm |
                                bus.ex_rs1_data | bus.ex_rs2_data), 64'd0);
    sb.delete();
    m_live = 0; m_load = 0;
    @(posedge clk);
    #1;
    reset_n = 1;
    pc = 32'h200; step(1, 32'h0070_0293, 0, 0, 0, 0, st);
    chk("post_reset", 64'({bus.ex_valid, bus.ex_imm}), 64'({1'b1, 32'd7}));

    st = 0; v = 0; ins = 0; fl = 0;
    for (int n = 0; n < 600; n++) begin
      if (!st) begin
        v = ($urandom_range(0, 9) != 0);
        ins = rnd_instr();
        pc = pc + 4;
      end
      fl = ($urandom_range(0, 9) == 0);
      we = $urandom_range(0, 1);
      wid = 5'($urandom_range(0, 7));
      wd = $urandom;
      step(v, ins, fl, we, wid, wd, st);
    end
    repeat (3) step(0, 0, 0, 0, 0, 0, st);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
